// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle for the bit-serial adder.
//   start        request strobe, honoured only while the sequencer is idle
//   op_a, op_b   WIDTH-bit operands, sampled on an accepted start
//   cin          carry-in, sampled on an accepted start
//   sub          subtract select (present only with SERIAL_ADD_CTRL_SUB_EN)
//   busy         high while an operation is running or completing
//   done         one-cycle pulse; sum/cout valid while high
//   sum, cout    result, held until the next accepted start
// master: requester side; slave: the sequencer.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  modport master (output start, op_a, op_b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, op_a, op_b, cin, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer built around one full_adder.
// Operands are shifted LSB-first through the full_adder, one bit per clock;
// the carry is kept in a register and the result is assembled in a shift
// register. One operation takes WIDTH+2 cycles from accept to next accept.
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset; aborts any operation in flight
//   bus   serial_add_ctrl_if slave modport (start/op_a/op_b/cin in,
//         busy/done/sum/cout out)
// Optional build macro SERIAL_ADD_CTRL_SUB_EN adds bus.sub: when set at
// accept, B is latched inverted and the carry starts at 1 (A - B, cout=1
// meaning no borrow).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_a;
  logic             fa_b;
  logic             fa_ci;
  logic             fa_sum;
  logic             fa_co;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  full_adder u_fa (
    .a   (fa_a),
    .b   (fa_b),
    .ci  (fa_ci),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_comb begin
    fa_a  = a_sh_q[0];
    fa_b  = b_sh_q[0];
    fa_ci = carry_q;
    // Shift then overwrite the MSB so WIDTH==1 never forms a zero-width slice.
    sum_d            = sum_q >> 1;
    sum_d[WIDTH-1]   = fa_sum;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    b_load     = bus.sub ? ~bus.op_b : bus.op_b;
    carry_load = bus.sub | bus.cin;
`else
    b_load     = bus.op_b;
    carry_load = bus.cin;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            a_sh_q  <= bus.op_a;
            b_sh_q  <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= fa_co;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cout_q  <= fa_co;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl (WIDTH=8 main
// instance, WIDTH=1 regression instance). Expected {cout,sum} values are
// pushed when a start is driven and popped when done pulses.
module tb_serial_add_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sum", 64'(bus.sum), 64'(e[W-1:0]));
        check("cout", 64'(bus.cout), 64'(e[W]));
      end
    end
  end

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input int poke_at, input int rst_at);
    logic [W:0] e;
    int k;
    int busy_cycles;
    int done_at;
    int done_before;
    e = model(a, b, c, s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    bus.sub   = s;
`endif
    exp_q.push_back(e);
    done_before = done_cnt;
    k = 0;
    busy_cycles = 0;
    done_at = 0;
    @(negedge clk);
    // Operands may change freely once accepted.
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.cin   = 1'($urandom);
    forever begin
      k++;
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) done_at = k;
      if (bus.busy !== 1'b1) break;
      if (k >= 40) begin
        check("timeout", 64'(k), 64'd0);
        break;
      end
      bus.start = (k == poke_at);
      if (k == poke_at) bus.op_a = '0;
      rst = (k == rst_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    if (rst_at > 0) begin
      check("rst_busy_cycles", 64'(busy_cycles), 64'(rst_at));
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_sum", 64'(bus.sum), 64'd0);
      check("rst_cout", 64'(bus.cout), 64'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      repeat (W + 4) @(negedge clk);
      check("rst_no_done", 64'(done_cnt), 64'(done_before));
    end else begin
      check("busy_cycles", 64'(busy_cycles), 64'(W + 1));
      check("done_at", 64'(done_at), 64'(W + 1));
      repeat (2) @(negedge clk);
      check("idle_after", 64'(bus.busy), 64'd0);
      check("done_count", 64'(done_cnt), 64'(done_before + 1));
      check("sum_held", 64'(bus.sum), 64'(e[W-1:0]));
      check("cout_held", 64'(bus.cout), 64'(e[W]));
    end
  endtask

  task automatic w1_op(input logic a, input logic b, input logic c);
    int k;
    int busy_cycles;
    int done_at;
    logic s_at_done;
    logic c_at_done;
    logic [1:0] e;
    e = 2'(a) + 2'(b) + 2'(c);
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.op_a  = a;
    bus1.op_b  = b;
    bus1.cin   = c;
    @(negedge clk);
    bus1.start = 1'b0;
    k = 0;
    busy_cycles = 0;
    done_at = 0;
    s_at_done = 1'b0;
    c_at_done = 1'b0;
    forever begin
      k++;
      if (bus1.busy === 1'b1) busy_cycles++;
      if (bus1.done === 1'b1) begin
        done_at = k;
        s_at_done = bus1.sum[0];
        c_at_done = bus1.cout;
      end
      if (bus1.busy !== 1'b1 || k >= 10) break;
      @(negedge clk);
    end
    check("w1_busy_cycles", 64'(busy_cycles), 64'd2);
    check("w1_done_at", 64'(done_at), 64'd2);
    check("w1_sum", 64'(s_at_done), 64'(e[0]));
    check("w1_cout", 64'(c_at_done), 64'(e[1]));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.cin = 1'b0;
    bus1.start = 1'b0;
    bus1.op_a = '0;
    bus1.op_b = '0;
    bus1.cin = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    bus.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_sum", 64'(bus.sum), 64'd0);
    check("reset_cout", 64'(bus.cout), 64'd0);
    check("reset_w1_busy", 64'(bus1.busy), 64'd0);
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0);
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, 0);
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 3, 0);
    run_op(8'hAA, 8'h77, 1'b0, 1'b0, 0, 4);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0, 0);
    end
`ifdef SERIAL_ADD_CTRL_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 0);
    run_op(8'h00, 8'h01, 1'b1, 1'b1, 0, 0);
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
`endif

    w1_op(1'b1, 1'b1, 1'b1);
    w1_op(1'b1, 1'b0, 1'b0);
    w1_op(1'b0, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
